// File: rtl/ddp_hdr_parse.sv
// DDP receive-side header parser: buffers DDP pieces, passes REQ/ACK straight through and
// reassembles tagged SEND pieces (PID 0..3) into one descriptor. Optional eop check: DDP_PARSE_EOP_CHECK_EN.
`timescale 1ns/1ps

`ifndef PKT_TID_RANGE
`define PKT_TID_RANGE 55:48
`endif
`ifndef PKT_DATA_NUM_RANGE
`define PKT_DATA_NUM_RANGE 47:40
`endif

module ddp_hdr_parse #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [55:0] pkg2ParseRdmapHeader,
  input  logic [7:0]  pkg2ParseRdmapCtrl,
  input  logic [15:0] pkg2ParseDdpHeader,
  input  logic [7:0]  pkg2ParseDdpCtrl,
  input  logic        pkg2ParseValid,
  output logic        parseFull,
  input  logic        rdmapFull,
  output logic        parse2RdmapValid,
  output logic [55:0] parse2RdmapHeader,
  output logic [7:0]  parse2RdmapCtrl,
  output logic [35:0] parse2RdmapLen,
  output logic [15:0] parse2RdmapQN,
  output logic [2:0]  parse2RdmapNum,
  output logic        parseErr,
  output logic [2:0]  parseErrCode
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned EW       = 56 + 8 + 16 + 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  OP_SEND  = 4'b0000;
  localparam logic [3:0]  OP_REQ   = 4'b0011;
  localparam logic [3:0]  OP_ACK   = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_EMIT,
    S_DROP
  } state_t;

  state_t state_q, state_d;

  // Input FIFO
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  logic [EW-1:0] push_data;
  logic          ddp_ctrl_unused;

  // Descriptor and error registers
  logic [55:0] hdr_q, hdr_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [35:0] len_q, len_d;
  logic [15:0] qn_q, qn_d;
  logic [2:0]  num_q, num_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;

  // Head-of-FIFO fields
  logic [EW-1:0]             head;
  logic [55:0]               h_hdr;
  logic [7:0]                h_ctrl;
  logic [2:0]                h_pid;
  logic [3:0]                h_qn;
  logic [8:0]                h_len;
  logic                      h_sop, h_eop;
  logic [`PKT_TID_RANGE]     h_tid, tid_cur;
  logic [`PKT_DATA_NUM_RANGE] h_cnt, cnt_cur;
  logic                      h_send, h_untagged, h_badop;
  logic                      h_single, h_last;
  logic                      first_eop_bad, mid_eop_bad;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = pkg2ParseValid & ~full;
  assign push_data = {pkg2ParseRdmapHeader, pkg2ParseRdmapCtrl, pkg2ParseDdpHeader,
                      pkg2ParseDdpCtrl[7:6]};
  assign ddp_ctrl_unused = ^pkg2ParseDdpCtrl[5:0];

  assign head   = mem_q[rd_ptr_q];
  assign h_hdr  = head[81:26];
  assign h_ctrl = head[25:18];
  assign h_pid  = head[17:15];
  assign h_qn   = head[14:11];
  assign h_len  = head[10:2];
  assign h_sop  = head[1];
  assign h_eop  = head[0];
  assign h_tid  = h_hdr[`PKT_TID_RANGE];
  assign h_cnt  = h_hdr[`PKT_DATA_NUM_RANGE];

  assign tid_cur = hdr_q[`PKT_TID_RANGE];
  assign cnt_cur = hdr_q[`PKT_DATA_NUM_RANGE];

  assign h_send     = (h_ctrl[3:0] == OP_SEND);
  assign h_untagged = (h_ctrl[3:0] == OP_REQ) || (h_ctrl[3:0] == OP_ACK);
  assign h_badop    = ~h_send & ~h_untagged;
  // A count of 0 is treated like 1 so a malformed header cannot stall ASSEMBLE forever.
  assign h_single   = (32'(h_cnt) <= 32'd1);
  assign h_last     = ((32'(h_pid) + 32'd1) == 32'(cnt_cur));

`ifdef DDP_PARSE_EOP_CHECK_EN
  assign first_eop_bad = (h_eop != h_single);
  assign mid_eop_bad   = (h_eop != h_last);
`else
  logic eop_unused;
  assign first_eop_bad = 1'b0;
  assign mid_eop_bad   = 1'b0;
  assign eop_unused    = h_eop;
`endif

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    ctrl_d     = ctrl_q;
    len_d      = len_q;
    qn_d       = qn_q;
    num_d      = num_q;
    pop        = 1'b0;
    err_code_d = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (h_untagged) begin
            hdr_d   = h_hdr;
            ctrl_d  = h_ctrl;
            len_d   = '0;
            qn_d    = '0;
            num_d   = '0;
            state_d = S_EMIT;
          end else if (h_badop) begin
            err_code_d = 3'd5;
          end else begin
            if (!h_sop || (h_pid != 3'd0)) begin
              err_code_d = 3'd1;
            end else if (h_len == '0) begin
              err_code_d = 3'd4;
            end else if (first_eop_bad) begin
              err_code_d = 3'd6;
            end
            if (err_code_d != 3'd0) begin
              state_d = S_DROP;
            end else begin
              hdr_d       = h_hdr;
              ctrl_d      = h_ctrl;
              len_d       = '0;
              len_d[8:0]  = h_len - 9'd1;
              qn_d        = {h_qn, 12'd0};
              num_d       = 3'd1;
              state_d     = h_single ? S_EMIT : S_ASSEMBLE;
            end
          end
        end
      end

      S_ASSEMBLE: begin
        if (!empty) begin
          if (h_badop) begin
            pop        = 1'b1;
            err_code_d = 3'd5;
          end else begin
            if (h_sop) begin
              err_code_d = 3'd1;
            end else if (!h_send || (h_pid != num_q) || (h_pid > 3'd3)) begin
              err_code_d = 3'd2;
            end else if (h_tid != tid_cur) begin
              err_code_d = 3'd3;
            end else if (h_len == '0) begin
              err_code_d = 3'd4;
            end else if (mid_eop_bad) begin
              err_code_d = 3'd6;
            end
            // Offending head stays queued; DROP keeps it if it opens a new message.
            if (err_code_d != 3'd0) begin
              state_d = S_DROP;
            end else begin
              pop = 1'b1;
              for (int unsigned p = 0; p < 4; p++) begin
                if (h_pid == 3'(p)) begin
                  len_d[9*p +: 9]     = h_len - 9'd1;
                  qn_d[4*(3-p) +: 4]  = h_qn;
                end
              end
              num_d = num_q + 3'd1;
              if (h_last) begin
                state_d = S_EMIT;
              end
            end
          end
        end
      end

      S_EMIT: begin
        if (!rdmapFull) begin
          state_d = S_IDLE;
        end
      end

      S_DROP: begin
        if (!empty) begin
          if (h_sop && (h_pid == 3'd0)) begin
            state_d = S_IDLE;
          end else begin
            pop = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if ((err_code_d == 3'd0) && pkg2ParseValid && full) begin
      err_code_d = 3'd7;
    end
    err_d = (err_code_d != 3'd0);

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hdr_q      <= '0;
      ctrl_q     <= '0;
      len_q      <= '0;
      qn_q       <= '0;
      num_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hdr_q      <= hdr_d;
      ctrl_q     <= ctrl_d;
      len_q      <= len_d;
      qn_q       <= qn_d;
      num_q      <= num_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign parseFull         = full;
  assign parse2RdmapValid  = (state_q == S_EMIT);
  assign parse2RdmapHeader = hdr_q;
  assign parse2RdmapCtrl   = ctrl_q;
  assign parse2RdmapLen    = len_q;
  assign parse2RdmapQN     = qn_q;
  assign parse2RdmapNum    = num_q;
  assign parseErr          = err_q;
  assign parseErrCode      = err_code_q;

endmodule

// File: tb/tb_ddp_hdr_parse.sv
// Scoreboard bench for ddp_hdr_parse: expected descriptors and error codes are queued as
// stimulus is driven and compared by a monitor when the parser produces them.
`timescale 1ns/1ps

`ifndef PKT_TID_RANGE
`define PKT_TID_RANGE 55:48
`endif
`ifndef PKT_DATA_NUM_RANGE
`define PKT_DATA_NUM_RANGE 47:40
`endif

module tb_ddp_hdr_parse;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [55:0] pkg2ParseRdmapHeader = '0;
  logic [7:0]  pkg2ParseRdmapCtrl = '0;
  logic [15:0] pkg2ParseDdpHeader = '0;
  logic [7:0]  pkg2ParseDdpCtrl = '0;
  logic        pkg2ParseValid = 1'b0;
  logic        parseFull;
  logic        rdmapFull = 1'b0;
  logic        parse2RdmapValid;
  logic [55:0] parse2RdmapHeader;
  logic [7:0]  parse2RdmapCtrl;
  logic [35:0] parse2RdmapLen;
  logic [15:0] parse2RdmapQN;
  logic [2:0]  parse2RdmapNum;
  logic        parseErr;
  logic [2:0]  parseErrCode;

  int checks = 0;
  int errors = 0;

  logic [118:0] exp_q[$];
  logic [2:0]   err_exp[$];
  logic [118:0] cur_desc;
  logic [118:0] mon_desc;
  logic [2:0]   mon_code;

  ddp_hdr_parse #(.DEPTH(4)) dut (
    .clock               (clock),
    .reset               (reset),
    .pkg2ParseRdmapHeader(pkg2ParseRdmapHeader),
    .pkg2ParseRdmapCtrl  (pkg2ParseRdmapCtrl),
    .pkg2ParseDdpHeader  (pkg2ParseDdpHeader),
    .pkg2ParseDdpCtrl    (pkg2ParseDdpCtrl),
    .pkg2ParseValid      (pkg2ParseValid),
    .parseFull           (parseFull),
    .rdmapFull           (rdmapFull),
    .parse2RdmapValid    (parse2RdmapValid),
    .parse2RdmapHeader   (parse2RdmapHeader),
    .parse2RdmapCtrl     (parse2RdmapCtrl),
    .parse2RdmapLen      (parse2RdmapLen),
    .parse2RdmapQN       (parse2RdmapQN),
    .parse2RdmapNum      (parse2RdmapNum),
    .parseErr            (parseErr),
    .parseErrCode        (parseErrCode)
  );

  always #5 clock = ~clock;

  assign cur_desc = {parse2RdmapHeader, parse2RdmapCtrl, parse2RdmapLen, parse2RdmapQN, parse2RdmapNum};

  function automatic logic [55:0] mk_hdr(input logic [7:0] tid, input logic [7:0] cnt, input logic [39:0] fill);
    logic [55:0] h;
    h = '0;
    h[39:0] = fill;
    h[`PKT_TID_RANGE] = tid;
    h[`PKT_DATA_NUM_RANGE] = cnt;
    return h;
  endfunction

  // Descriptor handshake happens on the next rising edge when valid & ~rdmapFull.
  always @(negedge clock) begin
    if (!reset) begin
      if (parse2RdmapValid && !rdmapFull) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL desc_unexpected: got %h, required no descriptor", cur_desc);
        end else begin
          mon_desc = exp_q.pop_front();
          if (cur_desc !== mon_desc) begin
            errors++;
            $display("FAIL desc_value: got %h, required %h", cur_desc, mon_desc);
          end
        end
      end
      if (parseErr) begin
        checks++;
        if (err_exp.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected: got code %0d, required no error", parseErrCode);
        end else begin
          mon_code = err_exp.pop_front();
          if (parseErrCode !== mon_code) begin
            errors++;
            $display("FAIL err_code: got %0d, required %0d", parseErrCode, mon_code);
          end
        end
      end
    end
  end

  task automatic put(input logic [55:0] h, input logic [7:0] c, input logic [15:0] d, input logic [7:0] dc);
    pkg2ParseRdmapHeader = h;
    pkg2ParseRdmapCtrl   = c;
    pkg2ParseDdpHeader   = d;
    pkg2ParseDdpCtrl     = dc;
    pkg2ParseValid       = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    pkg2ParseValid = 1'b0;
    for (int c = 0; c < 80 && (exp_q.size() != 0 || err_exp.size() != 0); c++) @(negedge clock);
    repeat (8) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (parse2RdmapValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", parse2RdmapValid); end
    checks++; if (parseFull !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, required 0", parseFull); end
    checks++; if (cur_desc !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", cur_desc); end
    checks++; if (parseErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", parseErr); end
    checks++; if (parseErrCode !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d, required 0", parseErrCode); end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_untagged();
    logic [55:0] h;
    h = mk_hdr(8'h11, 8'd1, 40'h12_3456_789A);
    exp_q.push_back({h, 8'h03, 36'd0, 16'd0, 3'd0});
    put(h, 8'h03, 16'h0006, 8'hC0);
    pkg2ParseValid = 1'b0;
    @(negedge clock);
    checks++; if (parse2RdmapValid !== 1'b0) begin errors++; $display("FAIL req_latency_n1: got valid %b, required 0", parse2RdmapValid); end
    @(negedge clock);
    checks++; if (parse2RdmapValid !== 1'b1) begin errors++; $display("FAIL req_latency_n2: got valid %b, required 1", parse2RdmapValid); end
    @(posedge clock);
    #1;
    h = mk_hdr(8'h12, 8'd1, 40'h00_0000_BEEF);
    exp_q.push_back({h, 8'hA7, 36'd0, 16'd0, 3'd0});
    put(h, 8'hA7, 16'h1234, 8'hC0);
    settle();
    checks++;
    if (exp_q.size() != 0 || err_exp.size() != 0) begin
      errors++; $display("FAIL untagged_drain: pending desc %0d err %0d, required 0 0", exp_q.size(), err_exp.size());
      exp_q.delete(); err_exp.delete();
    end
  endtask

  task automatic test_send3();
    logic [55:0] h;
    h = mk_hdr(8'h22, 8'd3, 40'hAB_CDEF_0123);
    exp_q.push_back({h, 8'h50, 9'h000, 9'h02F, 9'h01F, 9'h00F, 16'hABC0, 3'd3});
    put(h, 8'h50, {3'd0, 4'hA, 9'h010}, 8'h80);
    put(mk_hdr(8'h22, 8'd3, 40'h1), 8'h00, {3'd1, 4'hB, 9'h020}, 8'h00);
    put(mk_hdr(8'h22, 8'd3, 40'h2), 8'h00, {3'd2, 4'hC, 9'h030}, 8'h40);
    settle();
    checks++;
    if (exp_q.size() != 0 || err_exp.size() != 0) begin
      errors++; $display("FAIL send3_drain: pending desc %0d err %0d, required 0 0", exp_q.size(), err_exp.size());
      exp_q.delete(); err_exp.delete();
    end
  endtask

  task automatic test_stall_overrun();
    logic [55:0]  h;
    logic [118:0] e_send;
    h = mk_hdr(8'h23, 8'd3, 40'h55_AA55_AA55);
    e_send = {h, 8'h00, 9'h000, 9'h02F, 9'h01F, 9'h00F, 16'hABC0, 3'd3};
    exp_q.push_back(e_send);
    rdmapFull = 1'b1;
    put(h, 8'h00, {3'd0, 4'hA, 9'h010}, 8'h80);
    put(mk_hdr(8'h23, 8'd3, 40'h3), 8'h00, {3'd1, 4'hB, 9'h020}, 8'h00);
    put(mk_hdr(8'h23, 8'd3, 40'h4), 8'h00, {3'd2, 4'hC, 9'h030}, 8'h40);
    pkg2ParseValid = 1'b0;
    for (int c = 0; c < 20 && !parse2RdmapValid; c++) @(negedge clock);
    checks++; if (parse2RdmapValid !== 1'b1) begin errors++; $display("FAIL stall_valid_wait: got %b, required 1", parse2RdmapValid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (parse2RdmapValid !== 1'b1 || cur_desc !== e_send) begin
        errors++; $display("FAIL stall_hold%0d: got valid %b desc %h, required 1 %h", i, parse2RdmapValid, cur_desc, e_send);
      end
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) exp_q.push_back({mk_hdr(8'h80 + 8'(k), 8'd1, 40'(k)), 8'h03, 36'd0, 16'd0, 3'd0});
      else err_exp.push_back(3'd7);
      put(mk_hdr(8'h80 + 8'(k), 8'd1, 40'(k)), 8'h03, 16'h0000, 8'hC0);
      checks++;
      if (parseFull !== (k >= 3)) begin
        errors++; $display("FAIL stall_full_after%0d: got %b, required %b", k + 1, parseFull, (k >= 3));
      end
    end
    pkg2ParseValid = 1'b0;
    rdmapFull = 1'b0;
    settle();
    checks++;
    if (exp_q.size() != 0 || err_exp.size() != 0) begin
      errors++; $display("FAIL stall_drain: pending desc %0d err %0d, required 0 0", exp_q.size(), err_exp.size());
      exp_q.delete(); err_exp.delete();
    end
  endtask

  task automatic test_pid_seq();
    logic [55:0] ha, hb;
    ha = mk_hdr(8'h33, 8'd3, 40'h33);
    hb = mk_hdr(8'h44, 8'd2, 40'h44_4444);
    err_exp.push_back(3'd2);
    exp_q.push_back({hb, 8'h00, 9'h000, 9'h000, 9'h0FF, 9'h000, 16'h3400, 3'd2});
    put(ha, 8'h00, {3'd0, 4'h1, 9'h005}, 8'h80);
    put(ha, 8'h00, {3'd2, 4'h2, 9'h005}, 8'h00);
    put(ha, 8'h00, {3'd1, 4'h3, 9'h005}, 8'h00);
    put(hb, 8'h00, {3'd0, 4'h3, 9'h001}, 8'h80);
    put(hb, 8'h00, {3'd1, 4'h4, 9'h100}, 8'h40);
    settle();
    checks++;
    if (exp_q.size() != 0 || err_exp.size() != 0) begin
      errors++; $display("FAIL pidseq_drain: pending desc %0d err %0d, required 0 0", exp_q.size(), err_exp.size());
      exp_q.delete(); err_exp.delete();
    end
  endtask

  task automatic test_bad_opcode();
    logic [55:0] h;
    h = mk_hdr(8'h77, 8'd1, 40'h7777);
    err_exp.push_back(3'd5);
    exp_q.push_back({h, 8'h07, 36'd0, 16'd0, 3'd0});
    put(mk_hdr(8'h76, 8'd1, 40'h1), 8'h05, 16'h0000, 8'hC0);
    put(h, 8'h07, 16'h0000, 8'hC0);
    settle();
    checks++;
    if (exp_q.size() != 0 || err_exp.size() != 0) begin
      errors++; $display("FAIL badop_drain: pending desc %0d err %0d, required 0 0", exp_q.size(), err_exp.size());
      exp_q.delete(); err_exp.delete();
    end
  endtask

  task automatic test_eop();
    logic [55:0] h;
    h = mk_hdr(8'h55, 8'd2, 40'h5555);
`ifdef DDP_PARSE_EOP_CHECK_EN
    err_exp.push_back(3'd6);
`else
    exp_q.push_back({h, 8'h00, 9'h000, 9'h000, 9'h04F, 9'h03F, 16'h6700, 3'd2});
`endif
    put(h, 8'h00, {3'd0, 4'h6, 9'h040}, 8'h80);
    put(h, 8'h00, {3'd1, 4'h7, 9'h050}, 8'h00);
    settle();
    checks++;
    if (exp_q.size() != 0 || err_exp.size() != 0) begin
      errors++; $display("FAIL eop_drain: pending desc %0d err %0d, required 0 0", exp_q.size(), err_exp.size());
      exp_q.delete(); err_exp.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [55:0] h;
    h = mk_hdr(8'h66, 8'd3, 40'h6666);
    put(h, 8'h00, {3'd0, 4'h1, 9'h010}, 8'h80);
    put(h, 8'h00, {3'd1, 4'h2, 9'h010}, 8'h00);
    pkg2ParseValid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (parse2RdmapValid !== 1'b0 || parseFull !== 1'b0) begin errors++; $display("FAIL resetmid_flags: got valid %b full %b, required 0 0", parse2RdmapValid, parseFull); end
    checks++; if (cur_desc !== '0) begin errors++; $display("FAIL resetmid_data: got %h, required 0", cur_desc); end
    h = mk_hdr(8'h67, 8'd1, 40'h6767);
    exp_q.push_back({h, 8'h03, 36'd0, 16'd0, 3'd0});
    put(h, 8'h03, 16'h0000, 8'hC0);
    settle();
    checks++;
    if (exp_q.size() != 0 || err_exp.size() != 0) begin
      errors++; $display("FAIL resetmid_drain: pending desc %0d err %0d, required 0 0", exp_q.size(), err_exp.size());
      exp_q.delete(); err_exp.delete();
    end
  endtask

  initial begin
    test_reset();
    test_untagged();
    test_send3();
    test_stall_overrun();
    test_pid_seq();
    test_bad_opcode();
    test_eop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ddp_hdr_parse.md
# ddp_hdr_parse

Receive-side counterpart of the DDP header generator. Accepts DDP-framed pieces (RDMAP header/ctrl plus 16-bit DDP header and 8-bit DDP ctrl) from packet decapsulation. Untagged REQ/ACK pieces pass straight through. Tagged SEND pieces (up to 4 per message, PID 0..3) are reassembled into one descriptor per message, carrying packed piece lengths and queue numbers for the RDMAP receive logic.

## Interface
- DEPTH, 4: input FIFO entries (power of 2).
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- pkg2ParseRdmapHeader  in  56  RDMAP header; TID at `PKT_TID_RANGE, data count at `PKT_DATA_NUM_RANGE (MacroDefine.h).
- pkg2ParseRdmapCtrl  in  8  [3:0] opcode.
- pkg2ParseDdpHeader  in  16  {PID[15:13], QN[12:9], LEN[8:0]}.
- pkg2ParseDdpCtrl  in  8  {sop, eop, 6'd0}.
- pkg2ParseValid  in  1  piece present; accepted only when parseFull=0.
- parseFull  out  1  input FIFO full.
- rdmapFull  in  1  downstream back-pressure.
- parse2RdmapValid  out  1  descriptor valid; held until accepted.
- parse2RdmapHeader  out  56  RDMAP header of PID-0 piece.
- parse2RdmapCtrl  out  8  RDMAP ctrl of PID-0 piece.
- parse2RdmapLen  out  36  four 9-bit lengths, slot p = [9p+8:9p].
- parse2RdmapQN  out  16  four QN nibbles, PID0 in [15:12] … PID3 in [3:0].
- parse2RdmapNum  out  3  pieces received (0 for untagged).
- parseErr  out  1  one-cycle error pulse.
- parseErrCode  out  3  cause, valid with parseErr.

## Operation
- Input FIFO: push = pkg2ParseValid & ~parseFull; words offered while full are dropped.
- Head classification: opcode REQ (4'b0011) or ACK (4'b0111) = untagged; SEND (4'b0000) = tagged; other opcodes -> error 3'd5, popped, discarded.
- States: IDLE, ASSEMBLE, EMIT, DROP.
- IDLE, untagged head: load header/ctrl, Len=0, QN=0, Num=0; pop; -> EMIT.
- IDLE, tagged head: require sop=1, PID=0, LEN!=0, else error and -> DROP. Capture header/ctrl/TID, clear Len/QN slots, store slot0 = LEN-1, QN nibble0, expected PID=1, Num=1; pop. If data count (`PKT_DATA_NUM_RANGE) is 1 -> EMIT else -> ASSEMBLE.
- ASSEMBLE, each head: must be SEND, same TID, PID = expected, sop=0, LEN!=0, PID<=3. Store slot[PID] = LEN-1 (9-bit, wraps), nibble[PID] = QN, Num+1, pop. When PID = datacount-1 -> EMIT.
- EMIT: parse2RdmapValid=1, outputs stable; no pops. On ~rdmapFull: -> IDLE (valid drops next cycle).
- DROP: pop every head until one has sop=1 and PID=0, left unpopped; -> IDLE. Captured partial message discarded.
- Error codes: 1 sop/PID0 violation, 2 PID out of sequence or >3, 3 TID change mid-message, 4 LEN=0, 5 bad opcode, 6 eop check (see Configuration), 7 FIFO overrun (push attempt while full; reported without state change).
- Simultaneous error sources: lowest code wins.

## Timing
- Reset: parseFull=0, parse2RdmapValid=0, all data outputs 0, parseErr=0, parseErrCode=0, FIFO empty, state IDLE, Num=0.
- FIFO head visible the cycle after push; one piece consumed per cycle in IDLE/ASSEMBLE.
- Latency: final (or untagged) piece pushed at cycle N -> parse2RdmapValid at N+2.
- Back-to-back: pop resumes the cycle after EMIT is accepted; sustained rate one piece/cycle plus one EMIT cycle per message.
- parseErr asserted the cycle after the offending head is examined; single cycle.
- Reset mid-message: discards context and FIFO content, no descriptor produced.

## Configuration
- DDP_PARSE_EOP_CHECK_EN defined: final piece must have eop=1 and non-final pieces eop=0; mismatch -> error 6, -> DROP.
- Undefined: eop ignored; completion from data count only.

## Test plan
- Reset, then REQ (opcode 3, DDP hdr 16'h0006, ctrl 8'hC0) -> valid at N+2, Num=0, Len=0, header echoed.
- SEND, count 3, PIDs 0/1/2 LEN 9'h10/9'h20/9'h30, QN 4'hA/B/C -> Len[26:0] = {9'h2F,9'h1F,9'h0F}, QN=16'hABC0, Num=3.
- Same as previous with rdmapFull held high 5 cycles -> outputs stable, valid held, no extra pops, parseFull asserts after DEPTH further pushes.
- PID 0 then PID 2 -> parseErr code 2, pieces dropped until next sop/PID0 SEND, which then reassembles correctly.
- Push 6 pieces while rdmapFull stalls EMIT (DEPTH=4) -> error 7, 4 entries retained.
- With DDP_PARSE_EOP_CHECK_EN, 2-piece SEND with eop=0 on PID1 -> error 6, no descriptor; without macro -> descriptor Num=2.
